// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte scheduler in front of a single UART transmitter
module uart_tx_scheduler #(
    parameter int          NUM_REQ         = 4,
    parameter int          DATA_WIDTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd32,
    parameter int          TIMEOUT_CYCLES  = 65536
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [15:0]                   cfg_divisor,
    input  logic                          cfg_load,
    output logic [15:0]                   baud_divisor,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    input  logic                          tx_done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          sched_busy,
    output logic                          timeout_err,
    output logic [15:0]                   byte_count
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        winner;
    logic [IDW-1:0]        winner_inc;
    logic [IDW:0]          cand;
    logic                  found;
    logic                  grant_ok;
    logic                  accept;
    logic                  start_next;
    logic                  done_inc;
    logic                  abort;
    logic [TW-1:0]         timer;
    logic [15:0]           shadow_div;
    logic                  pend_load;
    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts at rr_ptr and wraps; cand is one bit wider so the wrap needs no modulo.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    assign grant_ok   = (state == S_IDLE) && enable && !tx_busy && !pend_load;
    assign req_ready  = (grant_ok && found) ? (NUM_REQ'(1) << winner) : '0;
    assign accept     = |req_ready;
    assign winner_inc = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tx_done wins over watchdog expiry when both land on the same cycle.
    always_comb begin
        state_next = state;
        start_next = 1'b0;
        done_inc   = 1'b0;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_START;
                    start_next = 1'b1;
                end
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    done_inc   = 1'b1;
                    state_next = S_IDLE;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // timer is zero in IDLE and START, so it counts cycles since tx_start rose.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            sched_busy  <= 1'b0;
            timeout_err <= 1'b0;
            byte_count  <= '0;
            timer       <= '0;
        end else begin
            tx_start    <= start_next;
            timeout_err <= abort;
            byte_count  <= byte_count + {15'd0, done_inc};
            if (state == S_IDLE) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
            if (accept) begin
                tx_data    <= req_bytes[winner];
                grant_id   <= winner;
                rr_ptr     <= winner_inc;
                sched_busy <= 1'b1;
            end else if (done_inc || abort) begin
                sched_busy <= 1'b0;
            end
        end
    end

    // Grants are held off while a load is pending, so no byte straddles two divisors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_divisor <= DEFAULT_DIVISOR;
            shadow_div   <= DEFAULT_DIVISOR;
            pend_load    <= 1'b0;
        end else if (cfg_load) begin
            shadow_div <= cfg_divisor;
            pend_load  <= 1'b1;
        end else if (pend_load && (state == S_IDLE) && !tx_busy) begin
            baud_divisor <= shadow_div;
            pend_load    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed bench for uart_tx_scheduler with a behavioural transmitter
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [15:0] cfg_divisor;
    logic        cfg_load;
    logic [15:0] baud_divisor;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        sched_busy;
    logic        timeout_err;
    logic [15:0] byte_count;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_hang = 1'b0;
    logic        m_ext  = 1'b0;
    int          m_dur  = 3;
    int          m_cnt  = 0;
    int          m_starts = 0;
    int          m_viol = 0;
    logic [7:0]  m_byte = 8'h00;
    logic [7:0]  m_rx   = 8'h00;
    logic [15:0] m_div  = 16'h0;
    logic [1:0]  grant_q [$];

    typedef struct {
        logic [3:0]  valid;
        logic [1:0]  id;
        logic [7:0]  data;
        logic [15:0] count;
    } vec_t;
    vec_t tbl [7];

    assign tx_busy = m_busy | m_ext;
    assign tx_done = m_done;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(8), .DEFAULT_DIVISOR(16'd32), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cfg_divisor(cfg_divisor), .cfg_load(cfg_load), .baud_divisor(baud_divisor),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_id(grant_id), .sched_busy(sched_busy), .timeout_err(timeout_err),
        .byte_count(byte_count)
    );

    // Transmitter model: busy from tx_start for m_dur cycles, then a one-cycle tx_done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_cnt  = 0;
            end else begin
                m_done = 1'b0;
                if (tx_start) begin
                    if (tx_busy) m_viol++;
                    m_busy = 1'b1;
                    m_cnt  = m_dur;
                    m_byte = tx_data;
                    m_div  = baud_divisor;
                    m_starts++;
                    grant_q.push_back(grant_id);
                end else if (m_busy && !m_hang) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_rx   = m_byte;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_byte(input logic [3:0] v, input logic [1:0] exp_id, input logic [7:0] exp_byte);
        int         n;
        logic [3:0] onehot;
        onehot    = 4'b0001 << exp_id;
        req_valid = v;
        #1;
        n = 0;
        while (req_ready == 4'b0000 && n < 200) begin
            tick();
            n++;
        end
        chk("req_ready", 32'(req_ready), 32'(onehot));
        tick();
        req_valid = 4'b0000;
        chk("tx_start", 32'(tx_start), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(exp_id));
        chk("tx_data", 32'(tx_data), 32'(exp_byte));
        chk("sched_busy", 32'(sched_busy), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sched_busy && n < 300) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(n < 300), 32'd1);
    endtask

    initial begin
        int n;
        int bad;
        int target;

        tbl[0] = '{4'b0001, 2'd0, 8'h10, 16'd2};
        tbl[1] = '{4'b1010, 2'd1, 8'h21, 16'd3};
        tbl[2] = '{4'b1010, 2'd3, 8'h43, 16'd4};
        tbl[3] = '{4'b0110, 2'd1, 8'h21, 16'd5};
        tbl[4] = '{4'b0110, 2'd2, 8'h32, 16'd6};
        tbl[5] = '{4'b0101, 2'd0, 8'h10, 16'd7};
        tbl[6] = '{4'b1000, 2'd3, 8'h43, 16'd8};

        reset       = 1'b1;
        enable      = 1'b1;
        req_valid   = 4'b0000;
        req_data    = 32'h433221A5;
        cfg_divisor = 16'd0;
        cfg_load    = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_sched_busy", 32'(sched_busy), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        chk("rst_baud", 32'(baud_divisor), 32'd32);
        reset = 1'b0;
        tick();

        start_byte(4'b0001, 2'd0, 8'hA5);
        tick();
        chk("tx_start_one_cycle", 32'(tx_start), 32'd0);
        wait_idle();
        chk("single_count", 32'(byte_count), 32'd1);
        chk("single_loopback", 32'(m_rx), 32'hA5);
        req_data = 32'h43322110;

        for (int i = 0; i < 7; i++) begin
            start_byte(tbl[i].valid, tbl[i].id, tbl[i].data);
            wait_idle();
            chk("tbl_count", 32'(byte_count), 32'(tbl[i].count));
            chk("tbl_loopback", 32'(m_rx), 32'(tbl[i].data));
        end

        grant_q.delete();
        target    = m_starts + 8;
        req_valid = 4'b1111;
        n = 0;
        while (m_starts < target && n < 400) begin
            tick();
            n++;
        end
        req_valid = 4'b0000;
        wait_idle();
        chk("fair_grants", 32'(grant_q.size()), 32'd8);
        for (int i = 0; i < grant_q.size(); i++) begin
            chk("fair_order", 32'(grant_q[i]), 32'(i % 4));
        end
        chk("fair_count", 32'(byte_count), 32'd16);

        m_hang = 1'b1;
        start_byte(4'b0100, 2'd2, 8'h32);
        n = 0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_latency", 32'(n), 32'd64);
        chk("timeout_sched_busy", 32'(sched_busy), 32'd0);
        chk("timeout_count", 32'(byte_count), 32'd16);
        tick();
        chk("timeout_pulse_width", 32'(timeout_err), 32'd0);

        req_valid = 4'b0001;
        #1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_ready != 4'b0000) bad++;
            tick();
        end
        chk("busy_blocks_grant", 32'(bad), 32'd0);
        m_hang = 1'b0;
        m_busy = 1'b0;
        start_byte(4'b0001, 2'd0, 8'h10);
        wait_idle();
        chk("after_hang_count", 32'(byte_count), 32'd17);

        m_dur = 10;
        start_byte(4'b0100, 2'd2, 8'h32);
        cfg_divisor = 16'd16;
        cfg_load    = 1'b1;
        tick();
        cfg_load  = 1'b0;
        req_valid = 4'b1000;
        bad = 0;
        n   = 0;
        while (sched_busy && n < 100) begin
            if (baud_divisor != 16'd32) bad++;
            tick();
            n++;
        end
        chk("div_held_in_byte", 32'(bad), 32'd0);
        chk("div_old_at_idle", 32'(baud_divisor), 32'd32);
        chk("pend_blocks_grant", 32'(req_ready), 32'd0);
        tick();
        chk("div_applied", 32'(baud_divisor), 32'd16);
        chk("grant_after_apply", 32'(req_ready), 32'b1000);
        start_byte(4'b1000, 2'd3, 8'h43);
        wait_idle();
        chk("new_rate_div", 32'(m_div), 32'd16);
        chk("new_rate_data", 32'(m_rx), 32'h43);
        chk("div_count", 32'(byte_count), 32'd19);

        cfg_divisor = 16'd40;
        cfg_load    = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("idle_load_1cyc", 32'(baud_divisor), 32'd16);
        tick();
        chk("idle_load_2cyc", 32'(baud_divisor), 32'd40);

        m_ext       = 1'b1;
        cfg_divisor = 16'd100;
        cfg_load    = 1'b1;
        tick();
        cfg_divisor = 16'd48;
        tick();
        cfg_load = 1'b0;
        tick();
        chk("load_blocked_busy", 32'(baud_divisor), 32'd40);
        m_ext = 1'b0;
        tick();
        chk("latest_load_wins", 32'(baud_divisor), 32'd48);

        m_dur = 6;
        start_byte(4'b0010, 2'd1, 8'h21);
        enable    = 1'b0;
        req_valid = 4'b1111;
        wait_idle();
        chk("enable_drop_completes", 32'(byte_count), 32'd20);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (req_ready != 4'b0000 || tx_start) bad++;
            tick();
        end
        chk("disabled_no_grant", 32'(bad), 32'd0);
        enable = 1'b1;
        start_byte(4'b1111, 2'd2, 8'h32);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_tx_start", 32'(tx_start), 32'd0);
        chk("midrst_sched_busy", 32'(sched_busy), 32'd0);
        chk("midrst_byte_count", 32'(byte_count), 32'd0);
        chk("midrst_baud", 32'(baud_divisor), 32'd32);
        chk("midrst_grant_id", 32'(grant_id), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("discarded_not_counted", 32'(byte_count), 32'd0);

        m_dur = 3;
        force dut.byte_count = 16'hFFFF;
        tick();
        release dut.byte_count;
        start_byte(4'b1000, 2'd3, 8'h43);
        wait_idle();
        chk("count_wrap", 32'(byte_count), 32'd0);
        start_byte(4'b1001, 2'd0, 8'h10);
        wait_idle();
        chk("count_after_wrap", 32'(byte_count), 32'd1);

        chk("tx_start_while_busy", 32'(m_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single uart_top transmitter between NUM_REQ byte-producing requesters using round-robin arbitration.
- Sequences uart_top: drives tx_data and a one-cycle tx_start, then waits for tx_done before granting the next byte.
- Owns baud_divisor. Applies a new divisor only while the transmitter is idle.
- Detects a hung transmitter with a per-byte watchdog.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, bits per UART character
DEFAULT_DIVISOR, 32, baud_divisor value after reset
TIMEOUT_CYCLES, 65536, max clk cycles from tx_start to tx_done before abort (>=4)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = new grants allowed; 0 = finish in-flight byte, grant nothing
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
cfg_divisor  input  16  requested baud divisor
cfg_load  input  1  pulse: request divisor update
baud_divisor  output  16  to uart_top.baud_divisor
tx_data  output  DATA_WIDTH  to uart_top.tx_data
tx_start  output  1  to uart_top.tx_start
tx_busy  input  1  from uart_top
tx_done  input  1  from uart_top
grant_id  output  $clog2(NUM_REQ)  requester of the current or last byte
sched_busy  output  1  high from accept until the byte completes or is aborted
timeout_err  output  1  one-cycle pulse on watchdog abort
byte_count  output  16  bytes completed with tx_done, wraps 0xFFFF->0

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, grant_id=0, tx_data=0, tx_start=0, sched_busy=0, timeout_err=0, byte_count=0, baud_divisor=DEFAULT_DIVISOR, pend_load=0.
- Registered outputs: all except req_ready. req_ready is combinational and nonzero only in IDLE with enable=1, tx_busy=0, pend_load=0.
- Arbitration: search order rr_ptr, rr_ptr+1, …, mod NUM_REQ; the first asserted req_valid wins.
- On accept, all updates take effect the next edge:
  - tx_data<=byte; grant_id<=winner; rr_ptr<=winner+1 mod NUM_REQ; sched_busy<=1; state->START.
- START: tx_start=1 for exactly this cycle; timer cleared. -> WAIT_DONE.
- WAIT_DONE:
  - tx_data held stable; timer increments each cycle.
  - tx_done=1 -> byte_count+1, sched_busy<=0, -> IDLE.
  - Else timer==TIMEOUT_CYCLES-1 -> timeout_err pulse, sched_busy<=0, -> IDLE; byte_count unchanged.
  - tx_done on the same cycle as expiry counts as success.
- Back-to-back: earliest next accept is the cycle after returning to IDLE, so at least 1 idle cycle separates tx_done from the next tx_start.
- Divisor update:
  - cfg_load captures cfg_divisor into a shadow register and sets pend_load.
  - Apply the shadow to baud_divisor in IDLE with tx_busy=0; clear pend_load. While pend_load=1, grants are blocked, so no byte uses a mixed divisor.
  - cfg_load while pending: the latest value wins.
  - cfg_load in IDLE: baud_divisor updates 2 cycles later.
- enable dropping mid-byte does not abort; the byte completes normally.
- req_valid deasserted before accept loses priority with no side effect.
- tx_busy=1 in IDLE (external or stale): no grants until it clears.
- Reset mid-byte: tx_start=0 immediately; the in-flight byte is discarded and not counted.

Test Plan:
- Single request: divisor 32, req_valid=4'b0001, data 0xA5 -> one req_ready[0] pulse, tx_start 1 cycle later for 1 cycle, rx loopback 0xA5, byte_count=1, grant_id=0.
- Fairness: all 4 requesters continuously valid, bytes 0x10/0x21/0x32/0x43, 8 bytes -> grant order 0,1,2,3,0,1,2,3; byte_count=8; no tx_start while tx_busy=1.
- Hung transmitter: tie tx_done=0 and tx_busy=1 after start, TIMEOUT_CYCLES=64 -> timeout_err pulse exactly 64 cycles after tx_start; IDLE; byte_count unchanged.
- Divisor reconfig: cfg_load with 16 during a byte on requester 2 -> baud_divisor stays 32 until tx_done, then 16; a pending req_valid[3] is granted only after the update; its byte decodes correctly at the new rate.
- Enable/reset: drop enable mid-byte -> byte completes, no further req_ready. Then assert reset mid-byte -> all outputs at reset values, baud_divisor=32, byte_count=0.
- Wrap: preload by sending 0xFFFF bytes (or force the counter) then one more byte -> byte_count=0; rr_ptr wraps from 3 to 0.
